cpu_run_ctrl: RTL and testbench

- Synthesizable run-control block for the single-cycle CPU with its data and instruction memories (SimpleCPU_DM_IM family).
- Replaces fixed-length free-running execution with controlled runs: hold the CPU in reset, release it, then run, single-step, stop on a cycle budget or on an instruction-address breakpoint.
- Sits between the board clock/reset and the CPU core. Observes the CPU bus (instruction address, write enable) and gates the CPU through a clock-enable.

---
 rtl/cpu_run_ctrl_pkg.sv | 28 ++
 rtl/cpu_run_ctrl_bp_match.sv | 27 ++
 rtl/cpu_run_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_cpu_run_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_run_ctrl_pkg.sv
// cpu_run_pkg: shared types for the CPU run controller.
//   run_state_t  : controller FSM states
//   halt_cause_t : reason reported on halt_cause (3 bits)
package cpu_run_pkg;

    localparam logic [2:0] HALT_NONE  = 3'd0;
    localparam logic [2:0] HALT_LIMIT = 3'd1;
    localparam logic [2:0] HALT_BP    = 3'd2;
    localparam logic [2:0] HALT_STOP  = 3'd3;
    localparam logic [2:0] HALT_WATCH = 3'd4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RST    = 3'd1,
        RUN    = 3'd2,
        PAUSED = 3'd3,
        HALTED = 3'd4
    } run_state_t;

    typedef enum logic [2:0] {
        CAUSE_NONE  = HALT_NONE,
        CAUSE_LIMIT = HALT_LIMIT,
        CAUSE_BP    = HALT_BP,
        CAUSE_STOP  = HALT_STOP,
        CAUSE_WATCH = HALT_WATCH
    } halt_cause_t;

endpackage

// File: rtl/cpu_run_ctrl_bp_match.sv
// bp_match: flags when the current instruction address hits any enabled
// breakpoint.
//   i_bp_en   : per-breakpoint enable
//   i_bp_addr : packed breakpoint addresses, bp0 in the LSBs
//   i_addr    : current instruction address
//   o_hit_c   : combinational hit flag
module bp_match #(
    parameter int unsigned NUM_BP = 2,
    parameter int unsigned ADDR_W = 8
) (
    input  logic [NUM_BP-1:0]        i_bp_en,
    input  logic [NUM_BP*ADDR_W-1:0] i_bp_addr,
    input  logic [ADDR_W-1:0]        i_addr,
    output logic                     o_hit_c
);

    // OR of enabled equality compares
    always_comb begin
        o_hit_c = 1'b0;
        for (int i = 0; i < int'(NUM_BP); i++) begin
            if (i_bp_en[i] && (i_bp_addr[i*ADDR_W +: ADDR_W] == i_addr)) begin
                o_hit_c = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: run control for the single-cycle CPU. Holds the CPU in
// reset, releases it, then runs / single-steps it through a clock enable,
// halting on a cycle budget, an instruction-address breakpoint or a stop
// request.
//   clk, reset (sync, active-low)
//   start / step / stop_req : control pulses; step_mode selects PAUSED entry
//   cycle_limit (0 = unlimited), bp_en / bp_addr : halt conditions
//   instr_addr, we : observed CPU bus
//   cpu_reset, cpu_en : CPU controls (cpu_en is combinational)
//   running, done, halt_cause, cycle_count, wr_count, halt_pc : status
// Optional: define CPU_RUN_CTRL_WATCH_EN to add watch_addr / data_addr and
// a data-write watchpoint (halt cause 4).
module cpu_run_ctrl
    import cpu_run_pkg::*;
#(
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned CYC_W      = 16,
    parameter int unsigned NUM_BP     = 2,
    parameter int unsigned RST_CYCLES = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     step,
    input  logic                     stop_req,
    input  logic                     step_mode,
    input  logic [CYC_W-1:0]         cycle_limit,
    input  logic [NUM_BP-1:0]        bp_en,
    input  logic [NUM_BP*ADDR_W-1:0] bp_addr,
    input  logic [ADDR_W-1:0]        instr_addr,
    input  logic                     we,
    output logic                     cpu_reset,
    output logic                     cpu_en,
    output logic                     running,
    output logic                     done,
    output logic [2:0]               halt_cause,
    output logic [CYC_W-1:0]         cycle_count,
    output logic [CYC_W-1:0]         wr_count,
    output logic [ADDR_W-1:0]        halt_pc
`ifdef CPU_RUN_CTRL_WATCH_EN
    ,
    input  logic [7:0]               watch_addr,
    input  logic [7:0]               data_addr
`endif
);

    localparam int unsigned RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [RC_W-1:0] RC_LAST = RC_W'(RST_CYCLES - 1);

    run_state_t        r_state;
    run_state_t        w_nxt_state;
    halt_cause_t       r_halt_cause;
    halt_cause_t       w_cause;
    logic [RC_W-1:0]   r_rst_cnt;
    logic [CYC_W-1:0]  r_cycle_count;
    logic [CYC_W-1:0]  r_wr_count;
    logic [ADDR_W-1:0] r_halt_pc;
    logic              r_cpu_reset;
    logic              r_running;
    logic              r_done;
    logic              r_step;      // step cycle in progress
    logic              r_bp_skip;   // first RUN cycle after resume from PAUSED
    logic              w_bp_hit;
    logic              w_bp_stop;
    logic              w_exec;
    logic              w_limit;
    logic              w_watch;
    logic              w_halt;
    logic              w_clear;
    logic              w_step_nxt;
    logic              w_skip_nxt;
    logic [CYC_W-1:0]  w_cyc_inc;
    logic [CYC_W-1:0]  w_wr_inc;

    bp_match #(
        .NUM_BP (NUM_BP),
        .ADDR_W (ADDR_W)
    ) u_bp_match (
        .i_bp_en   (bp_en),
        .i_bp_addr (bp_addr),
        .i_addr    (instr_addr),
        .o_hit_c   (w_bp_hit)
    );

    // CPU executes this cycle; a live breakpoint blocks the matching instruction
    always_comb begin
        w_bp_stop = w_bp_hit & ~r_bp_skip;
        w_exec    = 1'b0;
        if (r_state == RUN) begin
            w_exec = ~w_bp_stop;
        end else if (r_state == PAUSED) begin
            w_exec = r_step;
        end
    end

    // saturating counter increments
    assign w_cyc_inc = (&r_cycle_count) ? r_cycle_count : r_cycle_count + CYC_W'(1);
    assign w_wr_inc  = (&r_wr_count)    ? r_wr_count    : r_wr_count + CYC_W'(1);
    assign w_limit   = (cycle_limit != '0) && w_exec && (w_cyc_inc == cycle_limit);

`ifdef CPU_RUN_CTRL_WATCH_EN
    assign w_watch = w_exec & we & (data_addr == watch_addr);
`else
    assign w_watch = 1'b0;
`endif

    // next-state and halt decision
    always_comb begin
        w_nxt_state = r_state;
        w_cause     = CAUSE_NONE;
        w_halt      = 1'b0;
        w_clear     = 1'b0;
        w_step_nxt  = 1'b0;
        w_skip_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_nxt_state = RST;
                    w_clear     = 1'b1;
                end
            end
            RST: begin
                if (r_rst_cnt == RC_LAST) begin
                    w_nxt_state = step_mode ? PAUSED : RUN;
                end
            end
            RUN: begin
                if (stop_req) begin
                    w_halt  = 1'b1;
                    w_cause = CAUSE_STOP;
                end else if (w_watch) begin
                    w_halt  = 1'b1;
                    w_cause = CAUSE_WATCH;
                end else if (w_bp_stop) begin
                    w_halt  = 1'b1;
                    w_cause = CAUSE_BP;
                end else if (w_limit) begin
                    w_halt  = 1'b1;
                    w_cause = CAUSE_LIMIT;
                end
            end
            PAUSED: begin
                if (stop_req) begin
                    w_halt  = 1'b1;
                    w_cause = CAUSE_STOP;
                end else if (r_step && w_limit) begin
                    w_halt  = 1'b1;
                    w_cause = CAUSE_LIMIT;
                end else if (start) begin
                    w_nxt_state = RUN;
                    w_skip_nxt  = 1'b1;
                end else if (step && !r_step) begin
                    w_step_nxt = 1'b1;
                end
            end
            HALTED: begin
                if (start) begin
                    w_nxt_state = RST;
                    w_clear     = 1'b1;
                end
            end
            default: w_nxt_state = IDLE;
        endcase
        if (w_halt) begin
            w_nxt_state = HALTED;
        end
    end

    // state, counters and registered status
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_halt_cause  <= CAUSE_NONE;
            r_rst_cnt     <= '0;
            r_cycle_count <= '0;
            r_wr_count    <= '0;
            r_halt_pc     <= '0;
            r_cpu_reset   <= 1'b1;
            r_running     <= 1'b0;
            r_done        <= 1'b0;
            r_step        <= 1'b0;
            r_bp_skip     <= 1'b0;
        end else begin
            r_state     <= w_nxt_state;
            r_cpu_reset <= (w_nxt_state == IDLE) || (w_nxt_state == RST);
            r_running   <= (w_nxt_state == RUN);
            r_done      <= (w_nxt_state == HALTED);
            r_step      <= w_step_nxt;
            r_bp_skip   <= w_skip_nxt;
            r_rst_cnt   <= (r_state == RST) ? r_rst_cnt + RC_W'(1) : '0;
            if (w_clear) begin
                r_cycle_count <= '0;
                r_wr_count    <= '0;
                r_halt_cause  <= CAUSE_NONE;
            end else if (w_exec) begin
                r_cycle_count <= w_cyc_inc;
                if (we) begin
                    r_wr_count <= w_wr_inc;
                end
            end
            if (w_halt) begin
                r_halt_cause <= w_cause;
                r_halt_pc    <= instr_addr;
            end
        end
    end

    assign cpu_en      = w_exec;
    assign cpu_reset   = r_cpu_reset;
    assign running     = r_running;
    assign done        = r_done;
    assign halt_cause  = r_halt_cause;
    assign cycle_count = r_cycle_count;
    assign wr_count    = r_wr_count;
    assign halt_pc     = r_halt_pc;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb_cpu_run_ctrl: directed bench for cpu_run_ctrl. A tiny CPU model
// (PC advances on cpu_en, cleared by cpu_reset, writes when PC[1:0]==3)
// feeds the bus. Stimulus queues expected halt / snapshot records; a
// negedge monitor compares them when done rises or a snapshot is queued.
module tb_cpu_run_ctrl;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned CYC_W  = 16;
    localparam int unsigned NUM_BP = 2;

    logic                     clk;
    logic                     reset;
    logic                     start, step, stop_req, step_mode;
    logic [CYC_W-1:0]         cycle_limit;
    logic [NUM_BP-1:0]        bp_en;
    logic [NUM_BP*ADDR_W-1:0] bp_addr;
    logic [ADDR_W-1:0]        instr_addr;
    logic                     we;
    logic                     cpu_reset, cpu_en, running, done;
    logic [2:0]               halt_cause;
    logic [CYC_W-1:0]         cycle_count, wr_count;
    logic [ADDR_W-1:0]        halt_pc;
    logic [7:0]               pc;
`ifdef CPU_RUN_CTRL_WATCH_EN
    logic [7:0]               watch_addr, data_addr;
    assign data_addr = pc + 8'd1;
`endif

    assign instr_addr = pc;
    assign we         = (pc[1:0] == 2'b11);

    cpu_run_ctrl #(
        .ADDR_W     (ADDR_W),
        .CYC_W      (CYC_W),
        .NUM_BP     (NUM_BP),
        .RST_CYCLES (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .step        (step),
        .stop_req    (stop_req),
        .step_mode   (step_mode),
        .cycle_limit (cycle_limit),
        .bp_en       (bp_en),
        .bp_addr     (bp_addr),
        .instr_addr  (instr_addr),
        .we          (we),
        .cpu_reset   (cpu_reset),
        .cpu_en      (cpu_en),
        .running     (running),
        .done        (done),
        .halt_cause  (halt_cause),
        .cycle_count (cycle_count),
        .wr_count    (wr_count),
        .halt_pc     (halt_pc)
`ifdef CPU_RUN_CTRL_WATCH_EN
        ,
        .watch_addr  (watch_addr),
        .data_addr   (data_addr)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // CPU model: PC advances on each enabled cycle
    always @(posedge clk) begin
        if (!reset || cpu_reset === 1'b1) pc <= 8'd0;
        else if (cpu_en === 1'b1)         pc <= pc + 8'd1;
    end

    // expected record; -1 in a field means "do not compare"
    typedef struct {
        int cause; int cyc; int wr; int hpc;
        int run; int dn; int crst; int en; int rlen;
    } exp_t;

    exp_t halt_q[$];
    exp_t snap_q[$];
    bit   wait_q[$];
    int   hrd = 0, srd = 0, wrd = 0;
    int   checks = 0, passed = 0;
    int   en_cnt = 0, cur_len = 0, last_len = 0;
    logic prev_done = 1'b0;
    bit   end_req = 1'b0, end_ack = 1'b0;

    function automatic exp_t mk(input int cause, input int cyc, input int wr,
                                input int hpc, input int run, input int dn,
                                input int crst, input int en, input int rlen);
        exp_t e;
        e.cause = cause; e.cyc = cyc; e.wr = wr; e.hpc = hpc;
        e.run = run; e.dn = dn; e.crst = crst; e.en = en; e.rlen = rlen;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        checks++;
        if (act === 32'(exp)) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic cmp_rec(input string tag, input exp_t e);
        if (e.cause >= 0) chk({tag, " halt_cause"},  32'(halt_cause),  e.cause);
        if (e.cyc   >= 0) chk({tag, " cycle_count"}, 32'(cycle_count), e.cyc);
        if (e.wr    >= 0) chk({tag, " wr_count"},    32'(wr_count),    e.wr);
        if (e.hpc   >= 0) chk({tag, " halt_pc"},     32'(halt_pc),     e.hpc);
        if (e.run   >= 0) chk({tag, " running"},     32'(running),     e.run);
        if (e.dn    >= 0) chk({tag, " done"},        32'(done),        e.dn);
        if (e.crst  >= 0) chk({tag, " cpu_reset"},   32'(cpu_reset),   e.crst);
        if (e.en    >= 0) chk({tag, " cpu_en_cycles"}, 32'(en_cnt),    e.en);
        if (e.rlen  >= 0) chk({tag, " cpu_reset_len"}, 32'(last_len),  e.rlen);
    endtask

    // monitor: compares queued expectations against DUT outputs
    always @(negedge clk) begin
        if (done === 1'b1 && prev_done !== 1'b1) begin
            chk($sformatf("halt%0d queued", hrd), 32'(halt_q.size() > hrd), 1);
            if (halt_q.size() > hrd) begin
                cmp_rec($sformatf("halt%0d", hrd), halt_q[hrd]);
                hrd++;
            end
        end
        prev_done = done;
        if (snap_q.size() > srd) begin
            cmp_rec($sformatf("snap%0d", srd), snap_q[srd]);
            srd++;
        end
        if (wait_q.size() > wrd) begin
            chk($sformatf("wait%0d in_budget", wrd), 32'(wait_q[wrd]), 1);
            wrd++;
        end
        if (end_req && !end_ack) begin
            chk("halts_consumed", 32'(hrd), halt_q.size());
            end_ack = 1'b1;
        end
        if (cpu_reset === 1'b1) begin
            en_cnt = 0;
            cur_len++;
        end else begin
            if (cur_len > 0) last_len = cur_len;
            cur_len = 0;
            if (cpu_en === 1'b1) en_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_step();
        step = 1'b1;
        tick();
        step = 1'b0;
        tick();
    endtask

    task automatic wait_done(input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        wait_q.push_back(ok);
        tick();
    endtask

    task automatic wait_count(input int n, input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (cycle_count === CYC_W'(n)) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        wait_q.push_back(ok);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; start = 1'b0; step = 1'b0; stop_req = 1'b0;
        step_mode = 1'b0; cycle_limit = '0; bp_en = '0; bp_addr = '0;
`ifdef CPU_RUN_CTRL_WATCH_EN
        watch_addr = 8'hFF;
`endif
        tick();
        tick();
        reset = 1'b1;
        snap_q.push_back(mk(0, 0, 0, 0, 0, 0, 1, -1, -1));
        tick();

        // limit run: 180 cycles, PCs 0..179, writes at PC%4==3
        cycle_limit = 16'd180;
        halt_q.push_back(mk(1, 180, 45, 8'hB3, 0, 1, 0, 180, -1));
        pulse_start();
        wait_done(400);

        // breakpoint at 0x0C (bp1 at 0x05 disabled): 12 executed cycles
        cycle_limit = '0;
        bp_en   = 2'b01;
        bp_addr = {8'h05, 8'h0C};
        halt_q.push_back(mk(2, 12, 3, 8'h0C, 0, 1, 0, 12, 4));
        pulse_start();
        wait_done(100);

        // step mode: three single steps, then nine more up to the bp address
        step_mode = 1'b1;
        pulse_start();
        repeat (5) tick();
        for (int i = 0; i < 3; i++) pulse_step();
        snap_q.push_back(mk(0, 3, 0, -1, 0, 0, 0, 3, 4));
        tick();
        for (int i = 0; i < 9; i++) pulse_step();
        snap_q.push_back(mk(0, 12, 3, -1, 0, 0, 0, 12, -1));
        tick();
        // start+step together resumes; bp at 0x0C is passed, limit 20 halts
        cycle_limit = 16'd20;
        halt_q.push_back(mk(1, 20, 5, 8'h13, 0, 1, 0, 20, -1));
        start = 1'b1;
        step  = 1'b1;
        tick();
        start = 1'b0;
        step  = 1'b0;
        wait_done(100);

        // stop_req coincides with the limit-hitting cycle
        step_mode = 1'b0;
        bp_en = '0;
        cycle_limit = 16'd10;
        halt_q.push_back(mk(3, 10, 2, 8'h09, 0, 1, 0, 10, 4));
        pulse_start();
        wait_count(9, 50);
        stop_req = 1'b1;
        tick();
        stop_req = 1'b0;
        wait_done(5);
        // step and stop_req are ignored in HALTED
        stop_req = 1'b1;
        step = 1'b1;
        tick();
        stop_req = 1'b0;
        step = 1'b0;
        tick();
        snap_q.push_back(mk(3, 10, 2, 8'h09, 0, 1, 0, 10, -1));
        tick();

        // reset asserted mid-run
        cycle_limit = '0;
        pulse_start();
        wait_count(50, 100);
        reset = 1'b0;
        tick();
        snap_q.push_back(mk(0, 0, 0, 0, 0, 0, 1, -1, -1));
        reset = 1'b1;
        tick();

        // start+stop_req in IDLE: start wins, then stop after two RUN cycles
        start = 1'b1;
        stop_req = 1'b1;
        tick();
        start = 1'b0;
        stop_req = 1'b0;
        repeat (6) tick();
        snap_q.push_back(mk(0, 2, 0, -1, 1, 0, 0, 2, -1));
        halt_q.push_back(mk(3, 3, 0, 8'h02, 0, 1, 0, 3, -1));
        stop_req = 1'b1;
        tick();
        stop_req = 1'b0;
        wait_done(5);

`ifdef CPU_RUN_CTRL_WATCH_EN
        // watchpoint: write at PC 0x1F targets data address 0x20
        watch_addr = 8'h20;
        halt_q.push_back(mk(4, 32, 8, 8'h1F, 0, 1, 0, 32, 4));
        pulse_start();
        wait_done(100);
`endif

        end_req = 1'b1;
        tick();
        tick();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
